// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state and decoded-op types for alu_seq.
// Optional build macro: ALU_SEQ_REM_EN (enables op 4'b0011 = remainder).
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_REM = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIV
    } state_e;

    // Internal operation kind after decoding the 4-bit op field.
    typedef enum logic [2:0] {
        K_ADD,
        K_SUB,
        K_MUL,
        K_DIV,
        K_REM,
        K_BAD
    } kind_e;

    function automatic kind_e decode_op(input logic [3:0] op);
        case (op)
            OP_ADD:  return K_ADD;
            OP_SUB:  return K_SUB;
            OP_MUL:  return K_MUL;
            OP_DIV:  return K_DIV;
`ifdef ALU_SEQ_REM_EN
            OP_REM:  return K_REM;
`endif
            default: return K_BAD;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned WIDTH-bit restoring divider, one quotient bit per clock.
// load starts a division; valid pulses for one cycle when quotient and
// remainder are final. Sign handling lives in the caller.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // One restoring step per cycle: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        trial   = {rem_q, quot_q[WIDTH-1]};
        diff    = trial - {1'b0, dvs_q};
        if (load) begin
            rem_d  = '0;
            quot_d = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Partial remainder stays below the divisor, so diff fits in WIDTH bits when non-negative.
            if (!diff[WIDTH]) begin
                rem_d  = diff[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    // Divider state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with start/ready/done handshake: add, sub, mul in one
// execute cycle, divide through an iterative restoring divider.
// Optional build macro: ALU_SEQ_REM_EN (op 4'b0011 returns the remainder).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             div_zero,
    output logic             err
);

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d, kind_in;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sm_q, sm_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             alive_q, alive_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ov_q, ov_d, dz_q, dz_d, err_q, err_d, done_q, done_d;

    logic             accept, in_is_div, div_load, div_busy, div_valid;
    logic [WIDTH-1:0] a_mag, b_mag, div_quot, div_rem, q_signed, r_signed;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0] ex_y;
    logic             ex_ov, ex_dz, ex_err;

    // alive_q holds ready low until the first edge with rst_n released.
    assign ready     = rst_n & alive_q & (state_q == IDLE) & ~div_busy;
    assign accept    = start & ready;
    assign kind_in   = decode_op(op);
    assign in_is_div = (kind_in == K_DIV) || (kind_in == K_REM);
    assign a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;

    seq_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .valid     (div_valid),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Single-cycle results from latched operands: add/sub/mul, div-by-zero, invalid op.
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = a_q - b_q;
        ext_a  = sm_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b  = sm_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod   = ext_a * ext_b;
        ex_y   = y_q;
        ex_ov  = 1'b0;
        ex_dz  = 1'b0;
        ex_err = 1'b0;
        case (kind_q)
            K_ADD: begin
                ex_y  = sum[WIDTH-1:0];
                ex_ov = sm_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]))
                             : sum[WIDTH];
            end
            K_SUB: begin
                ex_y  = diff;
                ex_ov = sm_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]))
                             : (a_q < b_q);
            end
            K_MUL: begin
                ex_y  = prod[WIDTH-1:0];
                ex_ov = sm_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                             : (|prod[2*WIDTH-1:WIDTH]);
            end
            K_DIV, K_REM: begin
                // Divide ops only reach EXEC when the divisor is zero.
                ex_y  = '0;
                ex_dz = 1'b1;
            end
            default: ex_err = 1'b1;
        endcase
    end

    // Re-apply signs to the unsigned divider result.
    always_comb begin
        q_signed = q_neg_q ? -div_quot : div_quot;
        r_signed = r_neg_q ? -div_rem : div_rem;
    end

    // Control FSM: accept, dispatch to EXEC or DIV, and publish result/flags at done.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        a_d      = a_q;
        b_d      = b_q;
        sm_d     = sm_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        alive_d  = 1'b1;
        y_d      = y_q;
        ov_d     = ov_q;
        dz_d     = dz_q;
        err_d    = err_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    kind_d  = kind_in;
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    q_neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_d = signed_mode & a[WIDTH-1];
                    if (in_is_div && (b != '0)) begin
                        div_load = 1'b1;
                        state_d  = DIV;
                    end else begin
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                done_d  = 1'b1;
                y_d     = ex_y;
                ov_d    = ex_ov;
                dz_d    = ex_dz;
                err_d   = ex_err;
                state_d = IDLE;
            end
            DIV: begin
                if (div_valid) begin
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                    if (kind_q == K_REM) begin
                        y_d  = r_signed;
                        ov_d = 1'b0;
                    end else begin
                        // Only signed MIN / -1 yields a positive quotient with the top bit set.
                        y_d  = q_signed;
                        ov_d = sm_q & ~q_neg_q & div_quot[WIDTH-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= K_BAD;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            alive_q <= 1'b0;
            y_q     <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            alive_q <= alive_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign done     = done_q;
    assign y        = y_q;
    assign overflow = ov_q;
    assign div_zero = dz_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
// Build with ALU_SEQ_REM_EN defined to cover the remainder op.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       op;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             overflow;
    logic             div_zero;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int done_count;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .y           (y),
        .overflow    (overflow),
        .div_zero    (div_zero),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, then step cycles (sampling #1 after each edge) until done.
    task automatic do_op(input logic [3:0] o, input logic s, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] z, output int cycles);
        op = o; signed_mode = s; a = x; b = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_low_after_accept", 32'(ready), 32'd0);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done && cycles < 40);
        check("done_seen", 32'(done), 32'd1);
        check("ready_in_done_cycle", 32'(ready), 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [WIDTH-1:0] ey, input logic eov,
                              input logic edz, input logic eerr, input int elat, input int glat);
        check({tag, ":y"}, 32'(y), 32'(ey));
        check({tag, ":overflow"}, 32'(overflow), 32'(eov));
        check({tag, ":div_zero"}, 32'(div_zero), 32'(edz));
        check({tag, ":err"}, 32'(err), 32'(eerr));
        check({tag, ":latency"}, 32'(glat), 32'(elat));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_ADD; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:ready", 32'(ready), 32'd0);
        expect_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        check("rst:done", 32'(done), 32'd0);
        rst_n = 1'b1;
        check("ready_before_first_edge", 32'(ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_release", 32'(ready), 32'd1);

        do_op(OP_ADD, 1'b0, 8'd200, 8'd100, lat); expect_res("add_u_200_100", 8'd44, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_ADD, 1'b1, 8'd100, 8'd50, lat);  expect_res("add_s_100_50", 8'h96, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_ADD, 1'b1, 8'hFD, 8'd5, lat);    expect_res("add_s_m3_5", 8'h02, 1'b0, 1'b0, 1'b0, 1, lat);
        do_op(OP_SUB, 1'b0, 8'd3, 8'd5, lat);     expect_res("sub_u_3_5", 8'hFE, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_SUB, 1'b1, 8'd100, 8'h9C, lat);  expect_res("sub_s_100_m100", 8'hC8, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_SUB, 1'b0, 8'd9, 8'd4, lat);     expect_res("sub_u_9_4", 8'h05, 1'b0, 1'b0, 1'b0, 1, lat);
        do_op(OP_MUL, 1'b1, 8'hF8, 8'h10, lat);   expect_res("mul_s_m8_16", 8'h80, 1'b0, 1'b0, 1'b0, 1, lat);
        do_op(OP_MUL, 1'b1, 8'h10, 8'h08, lat);   expect_res("mul_s_16_8", 8'h80, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_MUL, 1'b0, 8'h10, 8'h10, lat);   expect_res("mul_u_16_16", 8'h00, 1'b1, 1'b0, 1'b0, 1, lat);
        do_op(OP_MUL, 1'b0, 8'd15, 8'd17, lat);   expect_res("mul_u_15_17", 8'hFF, 1'b0, 1'b0, 1'b0, 1, lat);

        // Signed -7/2 with stray start pulses while the divider is busy.
        op = OP_DIV; signed_mode = 1'b1; a = 8'hF9; b = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        do begin
            if (lat >= 2 && lat <= 4) begin
                start = 1'b1; op = OP_ADD; signed_mode = 1'b0; a = 8'd1; b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 40);
        start = 1'b0;
        check("div_busy:done_seen", 32'(done), 32'd1);
        expect_res("div_s_m7_2", 8'hFD, 1'b0, 1'b0, 1'b0, 9, lat);
        // Accept on the done cycle, then done must drop after its one-cycle pulse.
        do_op(OP_ADD, 1'b0, 8'd3, 8'd4, lat);     expect_res("add_back_to_back", 8'd7, 1'b0, 1'b0, 1'b0, 1, lat);
        @(posedge clk); #1;
        check("done_is_pulse", 32'(done), 32'd0);

        do_op(OP_DIV, 1'b0, 8'd200, 8'd7, lat);   expect_res("div_u_200_7", 8'h1C, 1'b0, 1'b0, 1'b0, 9, lat);
        do_op(OP_DIV, 1'b1, 8'd7, 8'hFE, lat);    expect_res("div_s_7_m2", 8'hFD, 1'b0, 1'b0, 1'b0, 9, lat);
        do_op(OP_DIV, 1'b0, 8'hFF, 8'h01, lat);   expect_res("div_u_255_1", 8'hFF, 1'b0, 1'b0, 1'b0, 9, lat);
        do_op(OP_DIV, 1'b0, 8'd5, 8'd0, lat);     expect_res("div_5_0", 8'h00, 1'b0, 1'b1, 1'b0, 1, lat);
        do_op(OP_DIV, 1'b1, 8'h80, 8'hFF, lat);   expect_res("div_s_min_m1", 8'h80, 1'b1, 1'b0, 1'b0, 9, lat);
        do_op(4'b0110, 1'b0, 8'd1, 8'd2, lat);    expect_res("op_0110", 8'h80, 1'b0, 1'b0, 1'b1, 1, lat);
        do_op(4'b0000, 1'b0, 8'd1, 8'd2, lat);    expect_res("op_0000", 8'h80, 1'b0, 1'b0, 1'b1, 1, lat);
`ifdef ALU_SEQ_REM_EN
        do_op(OP_REM, 1'b1, 8'hF9, 8'h02, lat);   expect_res("rem_s_m7_2", 8'hFF, 1'b0, 1'b0, 1'b0, 9, lat);
        do_op(OP_REM, 1'b1, 8'h80, 8'hFF, lat);   expect_res("rem_s_min_m1", 8'h00, 1'b0, 1'b0, 1'b0, 9, lat);
        do_op(OP_REM, 1'b0, 8'd5, 8'd0, lat);     expect_res("rem_5_0", 8'h00, 1'b0, 1'b1, 1'b0, 1, lat);
`else
        do_op(OP_REM, 1'b0, 8'd7, 8'd2, lat);     expect_res("op_0011_invalid", 8'h80, 1'b0, 1'b0, 1'b1, 1, lat);
`endif
        do_op(OP_ADD, 1'b0, 8'hFF, 8'd3, lat);    expect_res("add_u_255_3", 8'h02, 1'b1, 1'b0, 1'b0, 1, lat);

        // Reset four cycles into a division: no done, outputs cleared.
        op = OP_DIV; signed_mode = 1'b0; a = 8'd100; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_count = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort:ready", 32'(ready), 32'd0);
        check("abort:done", 32'(done), 32'd0);
        expect_res("abort", 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort:ready_before_edge", 32'(ready), 32'd0);
        @(posedge clk); #1;
        check("abort:ready_after_release", 32'(ready), 32'd1);
        repeat (12) begin
            if (done) done_count++;
            @(posedge clk); #1;
        end
        check("abort:no_done", 32'(done_count), 32'd0);
        do_op(OP_ADD, 1'b0, 8'd3, 8'd4, lat);     expect_res("add_after_abort", 8'd7, 1'b0, 1'b0, 1'b0, 1, lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the stack calculator's combinational ALU.
- Adds: WIDTH generalisation, signed/unsigned mode, start/ready/done handshake, iterative multi-cycle divider, and distinct overflow / divide-by-zero / invalid-op flags.
- Sits between the stack/queue control FSM (operand pops, op select) and the result push path.

Parameters:
- WIDTH, 32: operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1): divider iteration counter width (derived, do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div.
- signed_mode  in  1  1 = two's-complement, 0 = unsigned; sampled with start.
- a  in  WIDTH  operand A (dividend / minuend); sampled on accept.
- b  in  WIDTH  operand B (divisor / subtrahend); sampled on accept.
- ready  out  1  idle, able to accept.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- y  out  WIDTH  result, held until next done.
- overflow  out  1  result not representable in WIDTH bits.
- div_zero  out  1  div with b=0.
- err  out  1  op not one of the four encodings.

Behaviour:
- Reset: rst_n low at an edge sets state IDLE; y, overflow, div_zero, err, done = 0; ready=0 while rst_n low, 1 from first edge with rst_n high. Reset mid-division aborts, no done.
- Accept: start & ready at edge k latches a, b, op, signed_mode. Start while ready=0 is ignored, not queued.
- States: IDLE -> EXEC (add/sub/mul/invalid/div-by-zero) -> IDLE; IDLE -> DIV (WIDTH iterations) -> IDLE.
- Latency: add/sub/mul/invalid/div-by-zero: done=1 and outputs updated in cycle after edge k. Div: done exactly WIDTH+1 cycles after edge k.
- ready: low from the cycle after accept until the done cycle; high in the done cycle, so back-to-back accept on the done cycle is legal.
- Flags: all four (y, overflow, div_zero, err) written together at done; held otherwise.
- Add, unsigned: overflow = carry out.
- Add, signed: overflow = operands same sign and result sign differs.
- Sub, unsigned: overflow = borrow (a<b).
- Sub, signed: overflow = operand signs differ and result sign differs from a.
- Mul: y = low WIDTH bits of the 2*WIDTH product.
  - Unsigned: overflow = upper half nonzero.
  - Signed: overflow = upper half not the sign-extension of y.
- Div: restoring divider on magnitudes, one quotient bit per cycle.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN / -1: y=MIN, overflow=1.
  - b=0: y=0, div_zero=1, overflow=0, latency 1.
- Invalid op (any non-one-hot, including 0000): err=1, y unchanged, overflow=0, div_zero=0, latency 1.

Optional Feature:
- ALU_SEQ_REM_EN defined: op 0011 = remainder. Same divider path and WIDTH+1 latency; y = remainder; b=0 gives y=0, div_zero=1; MIN % -1 gives y=0, overflow=0.
- Undefined: 0011 is invalid (err=1).

Decomposition:
- Package alu_pkg: OP_ADD/OP_SUB/OP_MUL/OP_DIV/OP_REM 4-bit constants; state enum {IDLE, EXEC, DIV}.
- Sub-module seq_divider: unsigned WIDTH-bit restoring divider with load/busy/valid, quotient and remainder outputs. Sign handling stays in alu_seq.

Test Plan (WIDTH=8):
- Unsigned add 200+100 -> y=44, overflow=1, done one cycle after accept; signed 100+50 -> y=0x96, overflow=1.
- Signed mul -8*16 -> y=0x80, overflow=0; 16*8 -> y=0x80, overflow=1; unsigned 16*16 -> y=0, overflow=1.
- Signed div -7/2 -> y=0xFD (-3), done exactly 9 cycles after accept; start pulses during busy ignored; new start on done cycle accepted. REM_EN build: -7 rem 2 -> y=0xFF.
- Div 5/0 -> y=0, div_zero=1, latency 1. Signed -128/-1 -> y=0x80, overflow=1.
- op=0110 -> err=1, y unchanged from previous result, latency 1.
- rst_n low 4 cycles into a div -> no done; all outputs 0; ready=1 first cycle after release; next add 3+4 -> y=7.
